// File: rtl/general_pack.sv
// Shared types and helpers for the Avalon-ST message path.
package general_pack;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_MSG = 1'b1
    } msg_builder_sm_t;

    // Number of bits needed to index 'value' items (minimum 1).
    function automatic int log2up_func(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST beat bundle shared by the message path blocks.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    import general_pack::*;

    localparam int EMPTY_WIDTH = log2up_func(DATA_WIDTH_IN_BYTES);

    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic [EMPTY_WIDTH-1:0]           empty;

    modport master (output valid, data, sop, eop, empty, input rdy);
    modport slave  (input valid, data, sop, eop, empty, output rdy);

endinterface

// File: rtl/avalon_len_calc.sv
// Converts a byte length into a beat count and the empty-byte count of the last beat.
module avalon_len_calc
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16,
    localparam int LOG2_W             = log2up_func(DATA_WIDTH_IN_BYTES),
    localparam int BEATS_WIDTH        = LEN_WIDTH - LOG2_W + 1
) (
    input  logic [LEN_WIDTH-1:0]   msg_len,
    output logic [BEATS_WIDTH-1:0] beats,
    output logic [LOG2_W-1:0]      last_empty
);

    logic [LOG2_W-1:0]           rem;
    logic [LEN_WIDTH-LOG2_W-1:0] whole;

    assign rem   = msg_len[LOG2_W-1:0];
    assign whole = msg_len[LEN_WIDTH-1:LOG2_W];

    // A partial trailing word costs one extra beat.
    assign beats = {1'b0, whole} + BEATS_WIDTH'(|rem);

    // (W - rem) mod W is the two's complement of rem in LOG2_W bits.
    assign last_empty = '0 - rem;

endmodule

// File: rtl/avalon_msg_builder.sv
// Transmit-side Avalon-ST framer: length in, raw words in, framed message out.
// Optional build macro: AVALON_MSG_BUILDER_LEN_PREFETCH_EN (one-entry length
// holding register for zero-bubble back-to-back messages).
module avalon_msg_builder
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_WIDTH-1:0] msg_len,
    input  logic                 len_valid,
    output logic                 len_rdy,
    avalon_st_if.slave           raw_data,
    avalon_st_if.master          msg_out,
    output logic                 busy,
    output logic                 zero_len_indi
);

    localparam int LOG2_W      = log2up_func(DATA_WIDTH_IN_BYTES);
    localparam int BEATS_WIDTH = LEN_WIDTH - LOG2_W + 1;

    msg_builder_sm_t        state, state_nxt;
    logic [BEATS_WIDTH-1:0] beats_left, beats_left_nxt, in_beats;
    logic [LOG2_W-1:0]      last_empty, last_empty_nxt, in_empty;
    logic                   first, first_nxt;
    logic                   len_acc, len_zero, xfer, last_beat;
    logic                   unused_raw;

    // Framing fields on the raw stream carry no meaning here.
    assign unused_raw = ^{raw_data.sop, raw_data.eop, raw_data.empty};

    avalon_len_calc #(
        .DATA_WIDTH_IN_BYTES(DATA_WIDTH_IN_BYTES),
        .LEN_WIDTH          (LEN_WIDTH)
    ) u_len_calc (
        .msg_len   (msg_len),
        .beats     (in_beats),
        .last_empty(in_empty)
    );

`ifdef AVALON_MSG_BUILDER_LEN_PREFETCH_EN
    logic                   hold_valid, hold_valid_nxt;
    logic [LEN_WIDTH-1:0]   hold_len, hold_len_nxt;
    logic [BEATS_WIDTH-1:0] hold_beats;
    logic [LOG2_W-1:0]      hold_empty;

    avalon_len_calc #(
        .DATA_WIDTH_IN_BYTES(DATA_WIDTH_IN_BYTES),
        .LEN_WIDTH          (LEN_WIDTH)
    ) u_hold_calc (
        .msg_len   (hold_len),
        .beats     (hold_beats),
        .last_empty(hold_empty)
    );

    assign len_rdy = ~hold_valid;
`else
    assign len_rdy = (state == IDLE);
`endif

    assign len_acc   = len_valid & len_rdy;
    assign len_zero  = (msg_len == '0);
    assign last_beat = (beats_left == BEATS_WIDTH'(1));
    assign xfer      = (state == IN_MSG) & raw_data.valid & msg_out.rdy;
    assign busy      = (state == IN_MSG);

    // Next-state logic: length capture, per-transfer beat countdown, message chaining.
    always_comb begin
        state_nxt      = state;
        beats_left_nxt = beats_left;
        last_empty_nxt = last_empty;
        first_nxt      = first;
`ifdef AVALON_MSG_BUILDER_LEN_PREFETCH_EN
        hold_valid_nxt = hold_valid;
        hold_len_nxt   = hold_len;
`endif
        case (state)
            IDLE: begin
                if (len_acc && !len_zero) begin
                    state_nxt      = IN_MSG;
                    beats_left_nxt = in_beats;
                    last_empty_nxt = in_empty;
                    first_nxt      = 1'b1;
                end
            end
            IN_MSG: begin
                if (xfer) begin
                    beats_left_nxt = beats_left - BEATS_WIDTH'(1);
                    first_nxt      = 1'b0;
                    if (last_beat) begin
`ifdef AVALON_MSG_BUILDER_LEN_PREFETCH_EN
                        if (hold_valid) begin
                            beats_left_nxt = hold_beats;
                            last_empty_nxt = hold_empty;
                            first_nxt      = 1'b1;
                            hold_valid_nxt = 1'b0;
                        end else if (len_acc && !len_zero) begin
                            // Length arriving on the eop cycle goes straight to the live registers.
                            beats_left_nxt = in_beats;
                            last_empty_nxt = in_empty;
                            first_nxt      = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
`else
                        state_nxt = IDLE;
`endif
                    end
                end
`ifdef AVALON_MSG_BUILDER_LEN_PREFETCH_EN
                if (len_acc && !len_zero && !(xfer && last_beat)) begin
                    hold_valid_nxt = 1'b1;
                    hold_len_nxt   = msg_len;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: pass-through with framing, fields qualified by valid, eop bytes cleaned.
    always_comb begin
        msg_out.valid = 1'b0;
        msg_out.sop   = 1'b0;
        msg_out.eop   = 1'b0;
        msg_out.empty = '0;
        msg_out.data  = '0;
        raw_data.rdy  = 1'b0;
        if (state == IN_MSG) begin
            msg_out.valid = raw_data.valid;
            raw_data.rdy  = msg_out.rdy;
            if (raw_data.valid) begin
                msg_out.sop   = first;
                msg_out.eop   = last_beat;
                msg_out.empty = last_beat ? last_empty : '0;
                for (int i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
                    msg_out.data[8*i +: 8] = (last_beat && (i < int'(last_empty))) ?
                                             8'h00 : raw_data.data[8*i +: 8];
                end
            end
        end
    end

    // State and message-context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            beats_left    <= '0;
            last_empty    <= '0;
            first         <= 1'b0;
            zero_len_indi <= 1'b0;
`ifdef AVALON_MSG_BUILDER_LEN_PREFETCH_EN
            hold_valid    <= 1'b0;
            hold_len      <= '0;
`endif
        end else begin
            state         <= state_nxt;
            beats_left    <= beats_left_nxt;
            last_empty    <= last_empty_nxt;
            first         <= first_nxt;
            zero_len_indi <= len_acc & len_zero;
`ifdef AVALON_MSG_BUILDER_LEN_PREFETCH_EN
            hold_valid    <= hold_valid_nxt;
            hold_len      <= hold_len_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_avalon_msg_builder.sv
// Self-checking bench for avalon_msg_builder (W=16), directed plus randomized messages.
module tb_avalon_msg_builder;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] msg_len = '0;
    logic        len_valid = 1'b0;
    logic        len_rdy;
    logic        busy;
    logic        zero_len_indi;

    int n_chk  = 0;
    int n_pass = 0;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) raw_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) msg_if ();

    avalon_msg_builder #(
        .DATA_WIDTH_IN_BYTES(W),
        .LEN_WIDTH          (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .msg_len      (msg_len),
        .len_valid    (len_valid),
        .len_rdy      (len_rdy),
        .raw_data     (raw_if),
        .msg_out      (msg_if),
        .busy         (busy),
        .zero_len_indi(zero_len_indi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Reference: a beat carries the raw word with its lowest 'emp' bytes forced to zero.
    function automatic logic [127:0] exp_data(input logic [127:0] word, input int emp);
        logic [127:0] res;
        res = word;
        for (int i = 0; i < W; i++) if (i < emp) res[8*i +: 8] = 8'h00;
        return res;
    endfunction

    function automatic logic [127:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_vals();
        chk("rst_len_rdy", len_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_zero_indi", zero_len_indi, 0);
        chk("rst_raw_rdy", raw_if.rdy, 0);
        chk("rst_out_valid", msg_if.valid, 0);
        chk("rst_out_sop", msg_if.sop, 0);
        chk("rst_out_eop", msg_if.eop, 0);
        chk("rst_out_empty", msg_if.empty, 0);
        chk("rst_out_data", msg_if.data, 0);
    endtask

    // Offer a length, then stream its beats. Returns at a negedge.
    // abort_after >= 0 stops once that many beats have transferred (message left open).
    task automatic run_msg(input int len, input int stall_beat, input int stall_n,
                           input bit rnd, input int abort_after);
        int nb, emp, b, cyc, stalls, e;
        logic [127:0] word;
        bit v, r;
        @(negedge clk);
        raw_if.valid = 1'b0;
        msg_len      = 16'(len);
        len_valid    = 1'b1;
        #1 chk("len_rdy_idle", len_rdy, 1);
        @(negedge clk);
        len_valid = 1'b0;
        if (len == 0) begin
            #1;
            chk("zero_indi_hi", zero_len_indi, 1);
            chk("zero_out_valid", msg_if.valid, 0);
            chk("zero_raw_rdy", raw_if.rdy, 0);
            chk("zero_busy", busy, 0);
            @(negedge clk);
            #1 chk("zero_indi_lo", zero_len_indi, 0);
            return;
        end
        nb     = (len + W - 1) / W;
        emp    = (W - (len % W)) % W;
        b      = 0;
        cyc    = 0;
        stalls = 0;
        word   = rnd_word();
        while (b < nb && b != abort_after) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (b == stall_beat && stalls < stall_n) begin
                v = 1'b1;
                r = 1'b0;
                stalls++;
            end
            raw_if.valid = v;
            raw_if.data  = word;
            msg_if.rdy   = r;
            #1;
            e = (b == nb - 1) ? emp : 0;
            chk("busy", busy, 1);
            chk("out_valid", msg_if.valid, v);
            chk("raw_rdy", raw_if.rdy, r);
            if (v) begin
                chk("sop", msg_if.sop, (b == 0));
                chk("eop", msg_if.eop, (b == nb - 1));
                chk("empty", msg_if.empty, e);
                chk("data", msg_if.data, exp_data(word, e));
            end else begin
                chk("sop_idle", msg_if.sop, 0);
                chk("eop_idle", msg_if.eop, 0);
            end
            if (v && r) begin
                b++;
                word = rnd_word();
            end
            cyc++;
            @(negedge clk);
            if (cyc > 400) begin
                chk("msg_timeout", b, nb);
                break;
            end
        end
        if (abort_after >= 0) return;
        raw_if.valid = 1'b1;
        msg_if.rdy   = 1'b1;
        #1;
        chk("end_busy", busy, 0);
        chk("end_len_rdy", len_rdy, 1);
        chk("end_out_valid", msg_if.valid, 0);
        chk("end_raw_rdy", raw_if.rdy, 0);
        raw_if.valid = 1'b0;
    endtask

    initial begin
        int len;
        logic [127:0] w0, w1, w2;
        raw_if.valid = 1'b0;
        raw_if.sop   = 1'b0;
        raw_if.eop   = 1'b0;
        raw_if.empty = '0;
        raw_if.data  = '0;
        msg_if.rdy   = 1'b0;

        #1 check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_msg(40, -1, 0, 1'b0, -1);
        run_msg(16, -1, 0, 1'b0, -1);
        run_msg(0,  -1, 0, 1'b0, -1);
        run_msg(48,  1, 3, 1'b0, -1);

        // Reset in the middle of a 33-byte message, then a fresh 17-byte message.
        run_msg(33, -1, 0, 1'b0, 1);
        raw_if.valid = 1'b1;
        msg_if.rdy   = 1'b1;
        rst          = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        rst          = 1'b1;
        raw_if.valid = 1'b0;
        run_msg(17, -1, 0, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0:       len = 0;
                1:       len = W * $urandom_range(1, 4);
                default: len = $urandom_range(1, 100);
            endcase
            run_msg(len, -1, 0, 1'b1, -1);
        end

`ifdef AVALON_MSG_BUILDER_LEN_PREFETCH_EN
        // Lengths 20 then 5 back-to-back: second message follows eop with no bubble.
        @(negedge clk);
        w0 = rnd_word(); w1 = rnd_word(); w2 = rnd_word();
        msg_len = 16'd20; len_valid = 1'b1;
        @(negedge clk);
        msg_len = 16'd5;
        raw_if.valid = 1'b1; raw_if.data = w0; msg_if.rdy = 1'b1;
        #1;
        chk("pf_len_rdy_open", len_rdy, 1);
        chk("pf_b0_sop", msg_if.sop, 1);
        chk("pf_b0_eop", msg_if.eop, 0);
        @(negedge clk);
        len_valid = 1'b0; raw_if.data = w1;
        #1;
        chk("pf_len_rdy_full", len_rdy, 0);
        chk("pf_b1_eop", msg_if.eop, 1);
        chk("pf_b1_empty", msg_if.empty, 12);
        chk("pf_b1_data", msg_if.data, exp_data(w1, 12));
        @(negedge clk);
        raw_if.data = w2;
        #1;
        chk("pf_m2_sop", msg_if.sop, 1);
        chk("pf_m2_eop", msg_if.eop, 1);
        chk("pf_m2_empty", msg_if.empty, 11);
        chk("pf_m2_data", msg_if.data, exp_data(w2, 11));
        @(negedge clk);
        raw_if.valid = 1'b0;
        #1 chk("pf_end_busy", busy, 0);
`else
        w0 = '0; w1 = '0; w2 = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/avalon_msg_builder.md
# avalon_msg_builder

Transmit-side framer for the Avalon-ST message path. It accepts a message length in bytes, then consumes unframed data words from a raw word stream. It emits a well-formed message on an Avalon-ST master: `sop` on the first beat, `eop` on the last, correct `empty`, and unused bytes zeroed. Its output is what the downstream enforcer accepts without raising any indication. It sits between payload sources (DMA/readers) and the message fabric.

## Interface
- `DATA_WIDTH_IN_BYTES`, default 16: bytes per beat; must be a power of two, at least 2.
- `LEN_WIDTH`, default 16: width of the byte-length request.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `msg_len`  in  `LEN_WIDTH`  message length in bytes.
- `len_valid`  in  1  `msg_len` is valid.
- `len_rdy`  out  1  builder accepts `msg_len` this cycle.
- `raw_data`  `avalon_st_if.slave`  unframed payload; only `valid`, `rdy` and `data` are used, and `sop`/`eop`/`empty` are ignored.
- `msg_out`  `avalon_st_if.master`  framed message; width `DATA_WIDTH_IN_BYTES*8`, `empty` width `log2up_func(DATA_WIDTH_IN_BYTES)`.
- `busy`  out  1  high while in `IN_MSG`.
- `zero_len_indi`  out  1  one-cycle pulse when a zero length is accepted.

## Operation
- The state machine has two states, `IDLE` and `IN_MSG`. The reset state is `IDLE`.
- Length accept: a length is accepted when `len_valid & len_rdy`. From it the builder latches:
  - `beats_left = ceil(msg_len / W)`, where W = `DATA_WIDTH_IN_BYTES`. The register width is `LEN_WIDTH - log2(W) + 1`.
  - `last_empty = (W - msg_len mod W) mod W`.
- `IDLE` behaviour:
  - `len_rdy = 1`.
  - `raw_data.rdy = 0`.
  - `msg_out.valid = 0`.
  - On a nonzero accept, go to `IN_MSG` and set the `first` flag.
  - On a zero accept, pulse `zero_len_indi`, emit nothing and stay in `IDLE`.
- `IN_MSG` behaviour (combinational pass-through):
  - `msg_out.valid = raw_data.valid`.
  - `raw_data.rdy = msg_out.rdy`.
  - `msg_out.sop = first`.
  - `msg_out.eop = (beats_left == 1)`.
  - `msg_out.empty = eop ? last_empty : 0`.
  - `sop`, `eop` and `empty` are qualified by `valid`. While `valid` is 0 they are all 0.
- On each transfer (`msg_out.valid & msg_out.rdy`): decrement `beats_left` and clear `first`. On the `eop` transfer, return to `IDLE`.
- Data cleaning: on the `eop` beat, byte i (bits `8i+7:8i`) is driven to 0 when `i < empty`. All other bytes pass `raw_data.data` unchanged.
- Single-beat message (`msg_len <= W`): `sop` and `eop` are asserted on the same beat.
- `msg_len` an exact multiple of W: `last_empty = 0`.
- Reset mid-message: return to `IDLE` and clear all registers. Unconsumed raw words stay with the source.

## Timing
- Reset values of outputs:
  - `len_rdy = 1`.
  - `busy = 0`.
  - `zero_len_indi = 0`.
  - `raw_data.rdy = 0`.
  - All `msg_out` fields = 0.
- Length accept to first beat possible: the next cycle (1 cycle).
- Raw-to-output latency: 0 cycles (combinational). There is no buffering and backpressure propagates unchanged.
- `zero_len_indi` is registered and is high exactly one cycle after the accept.
- Without prefetch, back-to-back messages have a minimum gap of 2 cycles: the `eop` cycle, then the `IDLE` accept cycle, then the next `sop`.

## Configuration
- Macro: `AVALON_MSG_BUILDER_LEN_PREFETCH_EN`.
- When defined:
  - A one-entry holding register accepts the next length during `IN_MSG`. In this mode `len_rdy = !hold_valid`.
  - On the `eop` transfer with `hold_valid` set, load from the holding register and stay in `IN_MSG`. The next `sop` may follow `eop` on the very next cycle, with zero bubble.
  - A zero length entering the holding register is dropped at accept and pulses `zero_len_indi`.
- When undefined: there is no holding register and `len_rdy = (state == IDLE)`.

## Structure
- `general_pack`:
  - Add `msg_builder_sm_t` (`IDLE`, `IN_MSG`).
  - Reuse the existing `log2up_func`.
- Sub-module `avalon_len_calc`: combinational; takes `msg_len` and produces `beats` and `last_empty`. It is instantiated once, or twice when prefetch is enabled.

## Test plan
All scenarios use W=16.
- Length 40 with 3 raw words → 3 beats:
  - `sop` on beat 0.
  - `eop` on beat 2 with `empty = 8`.
  - Beat 2 bytes 0–7 = 0, bytes 8–15 = raw.
- Length 16 → 1 beat with `sop = eop = 1`, `empty = 0` and data unchanged. Then `IDLE`.
- Length 0 → `zero_len_indi` high for 1 cycle. `msg_out.valid` stays 0 and `raw_data.rdy` stays 0.
- Length 48 with `msg_out.rdy` low for 3 cycles on beat 1:
  - `raw_data.rdy` follows it low.
  - Beat 1 data holds.
  - `eop` only on the third transfer.
- Reset asserted after 1 of 3 beats of length 33:
  - All outputs return to reset values in the same cycle.
  - The next length-17 message starts with `sop`, and its second beat has `empty = 15`.
- With `AVALON_MSG_BUILDER_LEN_PREFETCH_EN`, lengths 20 then 5 → `eop` of message 1 is followed immediately on the next cycle by `sop`+`eop` of message 2 with `empty = 11`.
